// File: rtl/byte_serializer.sv
`default_nettype none
// ============================================================================
// Module      : byte_serializer
// Description : Accepts one byte per valid/ready handshake, waits for the
//               downstream deserializer to report ready, then sends the byte
//               MSB-first as a bit-serial stream with one write strobe per
//               bit. Every phase (setup, strobe high, strobe low, inter-byte
//               gap) is timed by a single shared 16-bit down-counter.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_serializer #(
    parameter int unsigned SETUP_CYCLES = 10,
    parameter int unsigned HIGH_CYCLES  = 10,
    parameter int unsigned LOW_CYCLES   = 10,
    parameter int unsigned GAP_CYCLES   = 300
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       valid_in,
    output logic       ready_out,
    input  logic       status_in,
    output logic       data_out,
    output logic       write_out,
    output logic       busy_out,
    output logic [7:0] sent_count_out
);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_WAIT_STATUS = 3'd1,
        ST_SETUP       = 3'd2,
        ST_HIGH        = 3'd3,
        ST_LOW         = 3'd4,
        ST_GAP         = 3'd5
    } state_t;

    // Counter reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [15:0] c_setup_load = 16'(SETUP_CYCLES - 1);
    localparam logic [15:0] c_high_load  = 16'(HIGH_CYCLES - 1);
    localparam logic [15:0] c_low_load   = 16'(LOW_CYCLES - 1);
    localparam logic [15:0] c_gap_load   = 16'(GAP_CYCLES - 1);

    state_t      r_state;
    logic [7:0]  shift_reg;
    logic [2:0]  bit_idx;
    logic [15:0] phase_cnt;

    logic        w_cnt_zero;
    logic        w_last_bit;

    assign w_cnt_zero = (phase_cnt == 16'd0);
    assign w_last_bit = (bit_idx == 3'd7);

    // Handshake and activity flags are pure decodes of the current state.
    assign ready_out = (r_state == ST_IDLE);
    assign busy_out  = (r_state != ST_IDLE);

    // Main sequencer: captures the byte, gates on status, then walks each bit
    // through setup/high/low and finishes with the inter-byte gap.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            shift_reg      <= 8'd0;
            bit_idx        <= 3'd0;
            phase_cnt      <= 16'd0;
            data_out       <= 1'b0;
            write_out      <= 1'b0;
            sent_count_out <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (valid_in) begin
                        shift_reg <= byte_in;
                        bit_idx   <= 3'd0;
                        r_state   <= ST_WAIT_STATUS;
                    end
                end

                // Status is only consulted here; once a byte starts it runs
                // to completion regardless of what the deserializer reports.
                ST_WAIT_STATUS: begin
                    if (status_in) begin
                        phase_cnt <= c_setup_load;
                        data_out  <= shift_reg[7];
                        r_state   <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    if (w_cnt_zero) begin
                        phase_cnt <= c_high_load;
                        write_out <= 1'b1;
                        r_state   <= ST_HIGH;
                    end else begin
                        phase_cnt <= phase_cnt - 16'd1;
                    end
                end

                ST_HIGH: begin
                    if (w_cnt_zero) begin
                        phase_cnt <= c_low_load;
                        write_out <= 1'b0;
                        r_state   <= ST_LOW;
                    end else begin
                        phase_cnt <= phase_cnt - 16'd1;
                    end
                end

                // End of a bit: either present the next bit (data_out only
                // ever changes on entry to setup) or close out the byte.
                ST_LOW: begin
                    if (w_cnt_zero) begin
                        if (!w_last_bit) begin
                            shift_reg <= {shift_reg[6:0], 1'b0};
                            data_out  <= shift_reg[6];
                            bit_idx   <= bit_idx + 3'd1;
                            phase_cnt <= c_setup_load;
                            r_state   <= ST_SETUP;
                        end else begin
                            sent_count_out <= sent_count_out + 8'd1;
                            phase_cnt      <= c_gap_load;
                            r_state        <= ST_GAP;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - 16'd1;
                    end
                end

                // data_out keeps the last bit sent while the gap elapses.
                ST_GAP: begin
                    if (w_cnt_zero) begin
                        r_state <= ST_IDLE;
                    end else begin
                        phase_cnt <= phase_cnt - 16'd1;
                    end
                end

                default: begin
                    r_state   <= ST_IDLE;
                    write_out <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_byte_serializer
// Description : Self-checking bench for byte_serializer. Two instances run:
//               one with default phase lengths, one with every phase at 1.
//               Expected strobe timing, bit values, ready return and byte
//               count are derived arithmetically from the handshake edge and
//               the edge at which status was first seen high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_serializer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    // Global edge counter used to timestamp every observed event.
    always @(posedge clock) cyc <= cyc + 1;

    logic       rst    [2];
    logic [7:0] byt    [2];
    logic       valid  [2];
    logic       status [2];
    logic       rdy    [2];
    logic       dat    [2];
    logic       wr     [2];
    logic       busy   [2];
    logic [7:0] sc     [2];

    int ev_q [2][$];
    int model_cnt [2];
    int n_cmp = 0;
    int n_mis = 0;

    byte_serializer u_def (
        .clock          (clock),
        .reset          (rst[0]),
        .byte_in        (byt[0]),
        .valid_in       (valid[0]),
        .ready_out      (rdy[0]),
        .status_in      (status[0]),
        .data_out       (dat[0]),
        .write_out      (wr[0]),
        .busy_out       (busy[0]),
        .sent_count_out (sc[0])
    );

    byte_serializer #(
        .SETUP_CYCLES (1),
        .HIGH_CYCLES  (1),
        .LOW_CYCLES   (1),
        .GAP_CYCLES   (1)
    ) u_one (
        .clock          (clock),
        .reset          (rst[1]),
        .byte_in        (byt[1]),
        .valid_in       (valid[1]),
        .ready_out      (rdy[1]),
        .status_in      (status[1]),
        .data_out       (dat[1]),
        .write_out      (wr[1]),
        .busy_out       (busy[1]),
        .sent_count_out (sc[1])
    );

    // Strobe monitor: logs every write_out transition as edge*4 + level*2 + data.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        logic prev = 1'b0;
        always @(posedge clock) begin
            #1;
            if (wr[g] !== prev) begin
                ev_q[g].push_back(cyc * 4 + (wr[g] ? 2 : 0) + (dat[g] ? 1 : 0));
                prev <= wr[g];
            end
        end
    end

    function automatic int p_s(input int idx); return (idx == 0) ? 10  : 1; endfunction
    function automatic int p_h(input int idx); return (idx == 0) ? 10  : 1; endfunction
    function automatic int p_l(input int idx); return (idx == 0) ? 10  : 1; endfunction
    function automatic int p_g(input int idx); return (idx == 0) ? 300 : 1; endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input int idx);
        check_eq("rst_ready", rdy[idx], 1);
        check_eq("rst_busy", busy[idx], 0);
        check_eq("rst_data", dat[idx], 0);
        check_eq("rst_write", wr[idx], 0);
        check_eq("rst_count", sc[idx], 0);
    endtask

    // Send one byte and check its complete serial waveform against the model.
    // hold keeps valid high with nxt presented for the following handshake;
    // swait is the number of post-handshake cycles that status stays low.
    task automatic send(input int idx, input logic [7:0] b, input bit hold,
                        input logic [7:0] nxt, input int swait);
        int s, h, l, g, p, hs, t, r, n, e, eb;
        bit found, done;
        s = p_s(idx); h = p_h(idx); l = p_l(idx); g = p_g(idx);
        p = s + h + l;
        t = 0; r = 0;

        @(negedge clock);
        byt[idx]    = b;
        valid[idx]  = 1'b1;
        status[idx] = (swait == 0);
        n = 0;
        while (!rdy[idx] && n < 5000) begin
            @(negedge clock);
            n++;
        end
        if (!rdy[idx]) begin
            check_eq("accept_timeout", 0, 1);
            valid[idx] = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        hs = cyc;
        check_eq("busy_after_hs", busy[idx], 1);
        if (hold) byt[idx] = nxt;
        else      valid[idx] = 1'b0;

        found = 1'b0;
        done  = 1'b0;
        n = 0;
        while (!done && n < 3000 + swait) begin
            @(negedge clock);
            n++;
            if (!found) status[idx] = (n > swait);
            else        status[idx] = 1'($urandom_range(0, 1));
            @(posedge clock);
            #1;
            if (!found && status[idx]) begin
                found = 1'b1;
                t = cyc;
            end
            if (rdy[idx]) begin
                done = 1'b1;
                r = cyc;
            end
        end
        status[idx] = 1'b1;
        check_eq("ready_timeout", done, 1);
        if (!done) begin
            ev_q[idx].delete();
            return;
        end

        model_cnt[idx] = (model_cnt[idx] + 1) % 256;
        check_eq("ready_edge", r, t + 8 * p + g);
        if (swait == 0) check_eq("hs_to_ready", r - hs, 1 + 8 * p + g);
        check_eq("sent_count", sc[idx], model_cnt[idx]);
        check_eq("strobe_events", ev_q[idx].size(), 16);
        if (ev_q[idx].size() >= 16) begin
            for (int k = 0; k < 8; k++) begin
                eb = int'(b[7 - k]);
                e = ev_q[idx].pop_front();
                check_eq("rise_edge", e / 4, t + s + k * p);
                check_eq("rise_level", (e / 2) % 2, 1);
                check_eq("rise_data", e % 2, eb);
                e = ev_q[idx].pop_front();
                check_eq("fall_edge", e / 4, t + s + k * p + h);
                check_eq("fall_level", (e / 2) % 2, 0);
                check_eq("fall_data", e % 2, eb);
            end
        end
        ev_q[idx].delete();
    endtask

    // Start a byte, assert reset while bit 4's strobe is high, confirm abort.
    task automatic reset_mid(input int idx);
        int n;
        @(negedge clock);
        byt[idx]    = 8'hC3;
        valid[idx]  = 1'b1;
        status[idx] = 1'b1;
        n = 0;
        while (!rdy[idx] && n < 5000) begin
            @(negedge clock);
            n++;
        end
        @(posedge clock);
        #1;
        valid[idx] = 1'b0;
        n = 0;
        while (ev_q[idx].size() < 9 && n < 2000) begin
            @(posedge clock);
            #2;
            n++;
        end
        check_eq("reach_bit4_high", ev_q[idx].size(), 9);
        check_eq("bit4_write_high", wr[idx], 1);
        @(negedge clock);
        rst[idx] = 1'b1;
        @(posedge clock);
        #2;
        check_eq("abort_write", wr[idx], 0);
        check_eq("abort_ready", rdy[idx], 1);
        check_eq("abort_busy", busy[idx], 0);
        check_eq("abort_count", sc[idx], 0);
        @(negedge clock);
        rst[idx] = 1'b0;
        model_cnt[idx] = 0;
        ev_q[idx].delete();
        repeat (20) @(negedge clock);
        check_eq("post_abort_quiet", ev_q[idx].size(), 0);
        check_eq("post_abort_ready", rdy[idx], 1);
    endtask

    logic [7:0] rnd_bytes [257];

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i]       = 1'b1;
            byt[i]       = 8'd0;
            valid[i]     = 1'b0;
            status[i]    = 1'b0;
            model_cnt[i] = 0;
        end
        for (int i = 0; i < 257; i++) rnd_bytes[i] = 8'($urandom);

        repeat (3) @(posedge clock);
        #1;
        check_idle_outputs(0);
        check_idle_outputs(1);
        @(negedge clock);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        repeat (20) @(negedge clock);
        check_eq("idle_quiet_def", ev_q[0].size(), 0);
        check_eq("idle_quiet_one", ev_q[1].size(), 0);
        check_idle_outputs(0);

        // Default timing: 0x80..0x87 back-to-back with valid held high.
        for (int k = 0; k < 8; k++)
            send(0, 8'(8'h80 + k), k < 7, 8'(8'h81 + k), 0);
        check_eq("count_after_8", sc[0], 8);

        // Status held low for 50 cycles after the handshake.
        send(0, rnd_bytes[256], 1'b0, 8'd0, 50);

        // Abort mid-byte, then a clean 0x5A.
        reset_mid(0);
        send(0, 8'h5A, 1'b0, 8'd0, 0);
        check_eq("count_after_abort", sc[0], 1);

        // All phases of length 1: 256 bytes, count must wrap to zero.
        for (int k = 0; k < 256; k++)
            send(1, rnd_bytes[k], k < 255, rnd_bytes[k + 1], int'($urandom_range(0, 3)));
        check_eq("count_wrap", sc[1], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    // Hang guard.
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached (compared %0d)", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/byte_serializer.md
# byte_serializer

Upstream source stage for the deserializer/queue path. Accepts one parallel byte per valid/ready handshake, waits for the deserializer's status to show ready, then emits the byte MSB-first as a bit-serial stream with one write strobe per bit. The cycle timing of each bit matches the deserializer's `data_in`/`write_in` protocol. It replaces bench-driven stimulus as the producer feeding `top`.

## Interface
- `SETUP_CYCLES`, default 10: cycles `data_out` is held stable with `write_out` low before each strobe.
- `HIGH_CYCLES`, default 10: cycles `write_out` stays high per bit.
- `LOW_CYCLES`, default 10: cycles `write_out` stays low after each strobe.
- `GAP_CYCLES`, default 300: idle cycles after the 8th bit before the next byte is accepted.
- All four parameters are in the range 1..65535. One shared 16-bit down-counter times every phase.

Ports:
- `clock` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `byte_in` in 8: parallel byte to send.
- `valid_in` in 1: `byte_in` is valid.
- `ready_out` out 1: block can accept a byte. The byte transfers on any edge where `valid_in` and `ready_out` are both high.
- `status_in` in 1: deserializer ready (connects to `status_out` of `top`).
- `data_out` out 1: serial bit, connects to `data_in`.
- `write_out` out 1: bit strobe, connects to `write_in`.
- `busy_out` out 1: high in every state except IDLE.
- `sent_count_out` out 8: number of completed bytes, wraps modulo 256.

## Operation
- State machine states: IDLE, WAIT_STATUS, SETUP, HIGH, LOW, GAP.
- Internal registers: `shift_reg` (8 bits), `bit_idx` (3 bits), `phase_cnt` (16 bits).
- IDLE:
  - `ready_out` = 1.
  - On handshake: capture `byte_in` into `shift_reg`, set `bit_idx` = 0, go to WAIT_STATUS.
- WAIT_STATUS:
  - Stay while `status_in` = 0.
  - When `status_in` is sampled as 1: load `phase_cnt` = SETUP_CYCLES-1, drive `data_out` = `shift_reg[7]`, go to SETUP.
- SETUP: count down. At 0, load HIGH_CYCLES-1, set `write_out` = 1, go to HIGH.
- HIGH: count down. At 0, load LOW_CYCLES-1, set `write_out` = 0, go to LOW.
- LOW: count down. At 0:
  - If `bit_idx` < 7: shift `shift_reg` left by 1, drive `data_out` with the new bit 7, increment `bit_idx`, load SETUP_CYCLES-1, go to SETUP.
  - If `bit_idx` = 7: increment `sent_count_out`, load GAP_CYCLES-1, go to GAP.
- GAP:
  - Count down. At 0, go to IDLE.
  - `data_out` is held at the last bit sent. `write_out` = 0.
- Bit order: `byte_in[7]` is sent first and `byte_in[0]` last.
- `status_in` is examined only in WAIT_STATUS. If it drops mid-byte, it is ignored and the byte completes.
- `valid_in` while `ready_out` = 0 is ignored. The producer holds the byte until the handshake.
- `sent_count_out`: 255 + 1 → 0, no flag.
- Reset mid-operation:
  - Next state is IDLE and the in-flight byte is discarded.
  - `write_out` drops on the edge where reset is sampled, so no truncated strobe is extended.

## Timing
- Reset values:
  - `data_out` = 0, `write_out` = 0, `sent_count_out` = 0.
  - `ready_out` = 1 (decoded from state IDLE).
  - `busy_out` = 0.
  - `shift_reg`, `bit_idx`, `phase_cnt` = 0.
- `data_out`, `write_out` and `sent_count_out` are registered. `ready_out` and `busy_out` are combinational decodes of the state.
- Handshake at edge k → WAIT_STATUS from k+1. With `status_in` = 1 at k+1, SETUP starts at k+2.
- Each bit takes exactly SETUP+HIGH+LOW cycles. The `write_out` pulse width is exactly HIGH_CYCLES.
- `data_out` changes only on SETUP entry and is stable through HIGH and LOW.
- Byte throughput, status already high: 1 + 8·(S+H+L) + GAP cycles from handshake to the next `ready_out`. With defaults this is 541.
- `sent_count_out` increments on the edge leaving the 8th LOW phase.
- Phase lengths of 1 are legal: each phase is then exactly one cycle.

## Test plan
- Reset held for 3 cycles then released → all outputs at their reset values, `ready_out` = 1, no `write_out` activity while `valid_in` = 0.
- Send 0x80 with `status_in` = 1, default parameters → `data_out` sequence 1,0,0,0,0,0,0,0; 8 strobes each exactly 10 cycles high; SETUP of bit 0 starts 2 cycles after the handshake; `sent_count_out` = 1; `ready_out` returns 541 cycles after the handshake.
- Bytes 0x80..0x87 back-to-back, `valid_in` held high, loop-back into `top` → `sent_count_out` = 8; dequeuing `top` 8 times yields `data_out` 0x80..0x87 in order.
- `status_in` = 0 for 50 cycles after the handshake, then 1 → `write_out` stays 0 during the wait; the first strobe starts SETUP_CYCLES+1 cycles after `status_in` rises. `status_in` dropping during bit 3 → the byte still completes with all 8 strobes.
- `reset` asserted during the HIGH phase of bit 4 → `write_out` = 0 and IDLE on the next edge, `sent_count_out` = 0; the following byte 0x5A is sent correctly from bit 7.
- Parameters all 1, 256 bytes sent → each bit takes 3 cycles; `sent_count_out` wraps to 0 after the 256th byte.
